// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest n with 2**n >= v; sizes the iteration counter for clog2(WIDTH+1).
  function automatic int clog2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/restoring_sub_step.sv
// One restoring iteration: shift in the next dividend bit, trial-subtract with one guard bit, keep or restore.
module restoring_sub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_r,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // r is always below 2**(step index), so dropping its MSB on the shift loses nothing.
  assign shifted = {r[WIDTH-2:0], q_msb};
  assign trial   = {1'b0, shifted} - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign next_r  = trial[WIDTH] ? shifted : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses WIDTH cycles after accept, start ignored while busy.
// Define DIV_ZERO_FLAG_EN to add the div_zero port and a single-cycle divide-by-zero short cut.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] next_r;
  logic             q_bit;

  restoring_sub_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .divisor(div_reg),
    .next_r (next_r),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      div_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            div_reg <= divisor;
            q_reg   <= dividend;
            r_reg   <= '0;
            count   <= CW'(WIDTH);
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= (divisor == '0);
            if (divisor == '0) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= ST_CALC;
              busy  <= 1'b1;
            end
`else
            state <= ST_CALC;
            busy  <= 1'b1;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          r_reg <= next_r;
          count <= count - CW'(1);
          // Last step: publish results on the same edge the final bit is formed.
          if (count == CW'(1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {q_reg[WIDTH-2:0], q_bit};
            remainder <= next_r;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized and directed bench for seq_restoring_divider against plain-arithmetic division.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division, wait for done, compare against ordinary / and %.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           exp_lat;
    int           edges;
    eq      = (b == '0) ? {W{1'b1}} : a / b;
    er      = (b == '0) ? a : a % b;
    exp_lat = W;
`ifdef DIV_ZERO_FLAG_EN
    if (b == '0) exp_lat = 0;
`endif
    check_eq("idle_busy", 32'(busy), 32'd0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    edges    = 0;
    while (!done && edges < 20) begin
      check_eq("calc_busy", 32'(busy), 32'd1);
      if (noise && edges < 2) begin
        start    = 1'b1;
        dividend = W'(14);
        divisor  = W'(2);
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    check_eq("latency", 32'(edges), 32'(exp_lat));
    check_eq("quotient", 32'(quotient), 32'(eq));
    check_eq("remainder", 32'(remainder), 32'(er));
    check_eq("done_busy", 32'(busy), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check_eq("div_zero", 32'(div_zero), 32'(b == '0));
`endif
  endtask

  initial begin
    bit saw_done;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_q", 32'(quotient), 32'd0);
    check_eq("rst_r", 32'(remainder), 32'd0);

    do_op(4'd13, 4'd3, 1'b0);
    tick();
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("q_held", 32'(quotient), 32'd4);

    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'd9, 4'd15, 1'b0);
    do_op(4'd0, 4'd5, 1'b1);
    do_op(4'd7, 4'd0, 1'b0);
    do_op(4'd6, 4'd3, 1'b0);

    // Reset sampled on the second CALC edge aborts the operation.
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_q", 32'(quotient), 32'd0);
    check_eq("abort_r", 32'(remainder), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check_eq("abort_dz", 32'(div_zero), 32'd0);
`endif
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    do_op(4'd12, 4'd5, 1'b0);

    // Reset and start on the same edge: reset wins.
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_eq("rst_start_busy", 32'(busy), 32'd0);
    tick();
    check_eq("rst_start_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = (($urandom % 8) == 0) ? '0 : W'($urandom);
      do_op(a, b, 1'($urandom));
      for (int g = 0; g < int'($urandom % 3); g++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
